// File: rtl/chacha_round_ctrl.sv
// ChaCha block sequencer: load, ROUNDS x 4 quarter-round steps, feed-forward, then hold the block until read.
// Latency: start sampled at edge E -> load_en E+1, qr_en E+2..E+4*ROUNDS+1, ff_en E+4*ROUNDS+2, valid E+4*ROUNDS+3.
// Backpressure: valid holds until read_ack; start is ignored while busy or while valid waits without read_ack.
module chacha_round_ctrl #(
    parameter int          ROUNDS   = 20,
    parameter logic [31:0] CTR_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        read_ack,
    output logic        load_en,
    output logic        qr_en,
    output logic [1:0]  qr_step,
    output logic        qr_diag,
    output logic        ff_en,
    output logic        busy,
    output logic        valid,
    output logic [31:0] blk_ctr,
    output logic        ctr_wrap
);

    // Double-round counter reaches ROUNDS/2 on the final step, so it needs one spare bit.
    localparam int             DW      = $clog2(ROUNDS / 2) + 1;
    localparam logic [DW-1:0]  DR_LAST = DW'(ROUNDS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FEED,
        S_VALID
    } state_t;

    state_t          state_q,    state_d;
    logic [1:0]      step_q,     step_d;
    logic            diag_q,     diag_d;
    logic [DW-1:0]   dr_cnt_q,   dr_cnt_d;
    logic [31:0]     blk_ctr_q,  blk_ctr_d;
    logic            ctr_wrap_q, ctr_wrap_d;
    logic            load_en_q,  load_en_d;
    logic            qr_en_q,    qr_en_d;
    logic [1:0]      qr_step_q,  qr_step_d;
    logic            qr_diag_q,  qr_diag_d;
    logic            ff_en_q,    ff_en_d;
    logic            busy_q,     busy_d;
    logic            valid_q,    valid_d;

    // Next-state, counter updates, and output decode from the next state so every output is a flop.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        diag_d     = diag_q;
        dr_cnt_d   = dr_cnt_q;
        blk_ctr_d  = blk_ctr_q;
        ctr_wrap_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d  = S_ROUND;
                step_d   = 2'd0;
                diag_d   = 1'b0;
                dr_cnt_d = '0;
            end
            S_ROUND: begin
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    diag_d = ~diag_q;
                    if (diag_q) begin
                        dr_cnt_d = dr_cnt_q + DW'(1);
                        if (dr_cnt_q == DR_LAST) begin
                            state_d = S_FEED;
                        end
                    end
                end
            end
            S_FEED: begin
                state_d = S_VALID;
            end
            S_VALID: begin
                // A start without read_ack is dropped; with read_ack it chains straight into the next load.
                if (read_ack) begin
                    blk_ctr_d  = blk_ctr_q + 32'd1;
                    ctr_wrap_d = (blk_ctr_q == 32'hFFFF_FFFF);
                    state_d    = start ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        load_en_d = (state_d == S_LOAD);
        qr_en_d   = (state_d == S_ROUND);
        qr_step_d = qr_en_d ? step_d : 2'd0;
        qr_diag_d = qr_en_d & diag_d;
        ff_en_d   = (state_d == S_FEED);
        busy_d    = load_en_d | qr_en_d | ff_en_d;
        valid_d   = (state_d == S_VALID);
    end

    // State, counters and registered outputs; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= 2'd0;
            diag_q     <= 1'b0;
            dr_cnt_q   <= '0;
            blk_ctr_q  <= CTR_INIT;
            ctr_wrap_q <= 1'b0;
            load_en_q  <= 1'b0;
            qr_en_q    <= 1'b0;
            qr_step_q  <= 2'd0;
            qr_diag_q  <= 1'b0;
            ff_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            diag_q     <= diag_d;
            dr_cnt_q   <= dr_cnt_d;
            blk_ctr_q  <= blk_ctr_d;
            ctr_wrap_q <= ctr_wrap_d;
            load_en_q  <= load_en_d;
            qr_en_q    <= qr_en_d;
            qr_step_q  <= qr_step_d;
            qr_diag_q  <= qr_diag_d;
            ff_en_q    <= ff_en_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign load_en  = load_en_q;
    assign qr_en    = qr_en_q;
    assign qr_step  = qr_step_q;
    assign qr_diag  = qr_diag_q;
    assign ff_en    = ff_en_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign blk_ctr  = blk_ctr_q;
    assign ctr_wrap = ctr_wrap_q;

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Scoreboard bench: three sequencer instances (20 rounds from 0, 20 rounds from 0xFFFFFFFF, 8 rounds).
// Stimulus pushes expected events (load/qr/ff/valid-rise/wrap with cycle and data); monitors pop on each event.
// Directed checks cover reset, start/read_ack ignore cases, back-to-back, wrap and abort.
module tb_chacha_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, ack_a;
    logic rst_c, start_c, ack_c;

    logic        load_a, qr_a, diag_a, ff_a, busy_a, valid_a, wrap_a;
    logic [1:0]  step_a;
    logic [31:0] ctr_a;
    logic        load_b, qr_b, diag_b, ff_b, busy_b, valid_b, wrap_b;
    logic [1:0]  step_b;
    logic [31:0] ctr_b;
    logic        load_c, qr_c, diag_c, ff_c, busy_c, valid_c, wrap_c;
    logic [1:0]  step_c;
    logic [31:0] ctr_c;

    chacha_round_ctrl #(.ROUNDS(20), .CTR_INIT(32'h0000_0000)) u_dut_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .read_ack(ack_a),
        .load_en(load_a), .qr_en(qr_a), .qr_step(step_a), .qr_diag(diag_a), .ff_en(ff_a),
        .busy(busy_a), .valid(valid_a), .blk_ctr(ctr_a), .ctr_wrap(wrap_a)
    );

    chacha_round_ctrl #(.ROUNDS(20), .CTR_INIT(32'hFFFF_FFFF)) u_dut_b (
        .clk(clk), .rst_n(rst_a), .start(start_a), .read_ack(ack_a),
        .load_en(load_b), .qr_en(qr_b), .qr_step(step_b), .qr_diag(diag_b), .ff_en(ff_b),
        .busy(busy_b), .valid(valid_b), .blk_ctr(ctr_b), .ctr_wrap(wrap_b)
    );

    chacha_round_ctrl #(.ROUNDS(8), .CTR_INIT(32'h0000_0000)) u_dut_c (
        .clk(clk), .rst_n(rst_c), .start(start_c), .read_ack(ack_c),
        .load_en(load_c), .qr_en(qr_c), .qr_step(step_c), .qr_diag(diag_c), .ff_en(ff_c),
        .busy(busy_c), .valid(valid_c), .blk_ctr(ctr_c), .ctr_wrap(wrap_c)
    );

    // Event kinds: 0 load (dat=blk_ctr), 1 qr step (dat={diag,step}), 2 ff, 3 valid rise (dat=blk_ctr), 4 wrap.
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] dat;
    } ev_t;

    ev_t sb[3][$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  s;
    logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int d, input int c, input int k, input logic [31:0] v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.dat  = v;
        sb[d].push_back(e);
    endtask

    // Expected trace of one block whose start is sampled at edge number st.
    task automatic push_run(input int d, input int st, input int rounds, input int nqr,
                            input logic [31:0] ctr, input bit full);
        push_ev(d, st, 0, ctr);
        for (int i = 0; i < nqr; i++) begin
            push_ev(d, st + 1 + i, 1, {29'd0, 1'(((i / 4) % 2)), 2'(i % 4)});
        end
        if (full) begin
            push_ev(d, st + 4 * rounds + 1, 2, 32'd0);
            push_ev(d, st + 4 * rounds + 2, 3, ctr);
        end
    endtask

    task automatic mon_evt(input int d, input int k, input logic [31:0] v);
        ev_t e;
        checks++;
        if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected event: kind %0d cyc %0d dat %h", d, k, cyc, v);
        end else begin
            e = sb[d].pop_front();
            if (e.kind != k || e.cyc != cyc || e.dat !== v) begin
                errors++;
                $display("FAIL dut%0d event: got kind %0d cyc %0d dat %h, expected kind %0d cyc %0d dat %h",
                         d, k, cyc, v, e.kind, e.cyc, e.dat);
            end
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor for the main instance: every enable cycle, valid rise and wrap pulse is a scoreboard event.
    always @(negedge clk) begin
        if (load_a)             mon_evt(0, 0, ctr_a);
        if (qr_a)               mon_evt(0, 1, {29'd0, diag_a, step_a});
        if (ff_a)               mon_evt(0, 2, 32'd0);
        if (valid_a && !pv_a)   mon_evt(0, 3, ctr_a);
        if (wrap_a)             mon_evt(0, 4, ctr_a);
        if (load_a || qr_a || ff_a)
            chk("excl_a", 32'(int'(load_a) + int'(qr_a) + int'(ff_a)), 32'd1);
        pv_a = valid_a;
    end

    // Monitor for the wrap instance: only block completion and counter wrap are tracked.
    always @(negedge clk) begin
        if (valid_b && !pv_b)   mon_evt(1, 3, ctr_b);
        if (wrap_b)             mon_evt(1, 4, ctr_b);
        pv_b = valid_b;
    end

    // Monitor for the 8-round instance.
    always @(negedge clk) begin
        if (load_c)             mon_evt(2, 0, ctr_c);
        if (qr_c)               mon_evt(2, 1, {29'd0, diag_c, step_c});
        if (ff_c)               mon_evt(2, 2, 32'd0);
        if (valid_c && !pv_c)   mon_evt(2, 3, ctr_c);
        if (wrap_c)             mon_evt(2, 4, ctr_c);
        pv_c = valid_c;
    end

    initial begin
        // Reset for 3 cycles with start asserted: nothing may launch.
        rst_a = 1'b0; start_a = 1'b1; ack_a = 1'b0;
        rst_c = 1'b0; start_c = 1'b1; ack_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {23'd0, load_a, qr_a, ff_a, busy_a, valid_a, wrap_a, diag_a, step_a}, 32'd0);
        chk("rst_outs_b", {23'd0, load_b, qr_b, ff_b, busy_b, valid_b, wrap_b, diag_b, step_b}, 32'd0);
        chk("rst_outs_c", {23'd0, load_c, qr_c, ff_c, busy_c, valid_c, wrap_c, diag_c, step_c}, 32'd0);
        chk("rst_ctr_a", ctr_a, 32'h0000_0000);
        chk("rst_ctr_b", ctr_b, 32'hFFFF_FFFF);
        chk("rst_ctr_c", ctr_c, 32'h0000_0000);
        rst_a = 1'b1; start_a = 1'b0;
        rst_c = 1'b1; start_c = 1'b0;
        @(negedge clk);

        // Single 20-round block, then read_ack back to IDLE; instance b wraps its counter.
        start_a = 1'b1;
        s = cyc + 1;
        push_run(0, s, 20, 80, 32'd0, 1'b1);
        push_ev(1, s + 82, 3, 32'hFFFF_FFFF);
        @(negedge clk);
        start_a = 1'b0;
        wait_to(s + 10);
        chk("busy_round", {31'd0, busy_a}, 32'd1);
        chk("valid_round", {31'd0, valid_a}, 32'd0);
        wait_to(s + 82);
        chk("valid_blk1", {31'd0, valid_a}, 32'd1);
        ack_a = 1'b1;
        push_ev(1, s + 83, 4, 32'd0);
        @(negedge clk);
        ack_a = 1'b0;
        chk("valid_after_ack", {31'd0, valid_a}, 32'd0);
        chk("busy_after_ack", {31'd0, busy_a}, 32'd0);
        chk("ctr_a_after1", ctr_a, 32'd1);
        chk("ctr_b_after1", ctr_b, 32'd0);
        @(negedge clk);
        chk("wrap_b_one_cycle", {31'd0, wrap_b}, 32'd0);

        // Second block with start held high throughout and a stray read_ack during ROUND.
        start_a = 1'b1;
        s = cyc + 1;
        push_run(0, s, 20, 80, 32'd1, 1'b1);
        push_ev(1, s + 82, 3, 32'd0);
        wait_to(s + 20);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        wait_to(s + 82);
        for (int k = 0; k < 10; k++) begin
            chk("valid_hold", {31'd0, valid_a}, 32'd1);
            if (k < 9) @(negedge clk);
        end

        // Back-to-back: read_ack with start chains straight into LOAD with the bumped counter.
        ack_a = 1'b1;
        s = cyc + 1;
        push_run(0, s, 20, 40, 32'd2, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        ack_a   = 1'b0;
        chk("b2b_load", {31'd0, load_a}, 32'd1);
        chk("b2b_ctr_a", ctr_a, 32'd2);
        chk("b2b_ctr_b", ctr_b, 32'd1);

        // Abort at ROUND cycle 40: everything drops and the counter returns to its reset value.
        wait_to(s + 40);
        rst_a = 1'b0;
        @(negedge clk);
        chk("abort_outs_a", {23'd0, load_a, qr_a, ff_a, busy_a, valid_a, wrap_a, diag_a, step_a}, 32'd0);
        chk("abort_ctr_a", ctr_a, 32'd0);
        chk("abort_ctr_b", ctr_b, 32'hFFFF_FFFF);
        rst_a = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_no_valid", {31'd0, valid_a}, 32'd0);

        // 8-round instance: read_ack in IDLE is ignored, then one block with valid at start+35.
        ack_c = 1'b1;
        @(negedge clk);
        ack_c = 1'b0;
        chk("idle_ack_ctr_c", ctr_c, 32'd0);
        start_c = 1'b1;
        s = cyc + 1;
        push_run(2, s, 8, 32, 32'd0, 1'b1);
        @(negedge clk);
        start_c = 1'b0;
        wait_to(s + 34);
        chk("valid_c", {31'd0, valid_c}, 32'd1);
        ack_c = 1'b1;
        @(negedge clk);
        ack_c = 1'b0;
        chk("ctr_c_after", ctr_c, 32'd1);
        chk("valid_c_after", {31'd0, valid_c}, 32'd0);
        repeat (5) @(negedge clk);

        // Every expected event must have been seen.
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("sb%0d_left", d), 32'(sb[d].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
